avalon_boot_ram: RTL and testbench
==================================

Name: avalon_boot_ram

Overview:
- Word-organised 32-bit RAM for CPU testbenches.
- Acts as the Avalon-MM slave on the top_level_cpu memory bus.
- Has a side-band preload port so the bench can write program words before and while the CPU runs.
- Only the low address bits decode, so the MIPS reset vector and low program addresses alias into the same array.

Parameters:
- DEPTH, 64: number of 32-bit words. Must be a power of two; 64 words covers the 8-bit byte address space of the preload port.
- WAIT_STATES, 1: clock cycles waitrequest stays high at the start of each bus transfer (0 to 7).

Ports:
- clk  in  1  single system clock; all bus activity on the rising edge.
- RAM_Reset  in  1  asynchronous, active-low reset.
- address  in  32  Avalon byte address from CPU. Word index = address[log2(DEPTH)+1:2]; bits [1:0] and upper bits ignored.
- write  in  1  Avalon write request.
- read  in  1  Avalon read request.
- waitrequest  out  1  stall the master while high.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes; bit n enables writedata[8n+7:8n].
- readdata  out  32  read data.
- instruction  in  32  preload word.
- inst_input  in  1  preload enable.
- inst_addr  in  8  preload byte address; word index = inst_addr[log2(DEPTH)+1:2].

Behaviour:
- Reset (RAM_Reset=0, asynchronous):
  - every memory word cleared to 0x00000000;
  - wait counter cleared;
  - waitrequest=0, readdata=0.
  - Reset takes effect immediately, including mid-transfer; the aborted transfer has no effect.
- Preload:
  - Level-sensitive and independent of clk.
  - While inst_input=1 and RAM_Reset=1, mem[inst_addr word] continuously follows instruction.
  - A change of inst_addr or instruction of 1 time unit, with no clock edge in between, must still land.
  - Preload has priority over a same-cycle Avalon write to the same word.
- Bus transfer start:
  - A transfer starts in any cycle where (read|write)=1 and no transfer is in progress.
  - If WAIT_STATES=0: waitrequest=0, and the transfer completes in that cycle.
  - Otherwise: waitrequest=1 combinationally from the cycle the request is seen. A counter counts WAIT_STATES rising edges; waitrequest then drops to 0 for exactly one cycle, the completion cycle.
  - After completion the counter returns to idle. A request still held in the next cycle starts a new transfer with fresh wait states, so back-to-back requests each pay WAIT_STATES.
  - If read and write both drop before completion, the transfer is abandoned and the counter returns to idle.
- Write:
  - Commits on the rising clk edge ending the completion cycle.
  - Only bytes with byteenable=1 change; byteenable=0000 changes nothing.
- Read:
  - During the completion cycle, readdata = mem[address word] combinationally, full 32 bits regardless of byteenable.
  - At all other times readdata=0.
- Read and write asserted together: treated as a write, readdata=0.
- Address decode:
  - Addresses beyond DEPTH words wrap by truncation.
  - Example: 0xBFC00004 and 0x00000004 hit the same word.
  - Unaligned bits [1:0] are ignored.
- Unwritten words read 0x00000000, a MIPS nop.

Test Plan:
- Reset then read: pulse RAM_Reset low, then read address 0x8 -> waitrequest high 1 cycle, then readdata=0x00000000 with waitrequest=0.
- Preload burst: inst_input=1; write 0x24030020@0x04, 0x2882F00F@0x08, 0x00000008@0x10 at 1-unit spacing, no clk edge between them -> bus reads of 0x4/0x8/0x10 return those words; 0x0 and 0xC return 0.
- Byte-enable write: word 0x8=0x2882F00F; write 0xAABBCCDD with byteenable=0101 -> readback 0x28BBF0DD.
- Aliasing: preload 0x12345678 at inst_addr 0x04 -> read of 0xBFC00004 returns 0x12345678.
- Wait-state handshake:
  - WAIT_STATES=1, read held 3 cycles -> waitrequest pattern 1,0,1 (second transfer starts).
  - WAIT_STATES=0 -> waitrequest constant 0.
- Async reset mid-write: assert write and drop RAM_Reset during its wait cycle -> waitrequest=0 immediately, target word 0 after reset release.
- End-to-end with top_level_cpu running the three preloaded words above -> CPU halts via jr $0, and register_v0=0x00000000 when active falls.

Source files
------------

// File: rtl/avalon_boot_ram.sv
// avalon_boot_ram: word-organised 32-bit RAM acting as the Avalon-MM slave
// on a CPU memory bus, with a level-sensitive side-band preload port.
//
// Bus handshake: a transfer starts in any cycle with (read|write)=1 while no
// transfer is in progress. waitrequest is high combinationally for the first
// WAIT_STATES cycles, then low for exactly one completion cycle. Read data is
// presented combinationally in that completion cycle. Write data commits on
// the rising edge that ends it. A transfer whose request drops early is
// abandoned.
//
// Storage is a latch array because preload must land without a clock edge.
// Bus writes are captured into registers at the completing edge (already
// byte-merged) and pass through the word latch while clk is high. A preload
// to the same word on that edge wins, and the bus write is discarded.
module avalon_boot_ram #(
   parameter int DEPTH       = 64,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        RAM_Reset,
   input  logic [31:0] address,
   input  logic        write,
   input  logic        read,
   output logic        waitrequest,
   input  logic [31:0] writedata,
   input  logic [3:0]  byteenable,
   output logic [31:0] readdata,
   input  logic [31:0] instruction,
   input  logic        inst_input,
   input  logic [7:0]  inst_addr
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = 3;
   localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);

   // Transfer FSM encoding
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          wr_pend_q, wr_pend_d;
   logic [AW-1:0] wr_word_q, wr_word_d;
   logic [31:0]   wr_data_q, wr_data_d;

   logic [31:0]   mem_q [DEPTH];

   logic [AW-1:0] bus_word;
   logic [AW-1:0] pre_word;
   logic [31:0]   inst_addr_ext;
   logic [31:0]   rd_word;
   logic [31:0]   merged;
   logic          req;
   logic          complete;
   logic          wait_c;
   logic          pre_hits_bus;
   logic          unused_bits;

   // Only the low address bits decode; everything else aliases
   assign inst_addr_ext = {24'b0, inst_addr};
   assign bus_word      = address[AW+1:2];
   assign pre_word      = inst_addr_ext[AW+1:2];
   assign unused_bits   = ^{address[31:AW+2], address[1:0],
                            inst_addr_ext[31:AW+2], inst_addr_ext[1:0]};

   assign req          = read | write;
   assign rd_word      = mem_q[bus_word];
   assign pre_hits_bus = inst_input & (pre_word == bus_word);

   // Transfer sequencing: wait-state counting, abandon and completion
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      complete = 1'b0;
      wait_c   = 1'b0;
      if (WAIT_STATES == 0) begin
         complete = req;
         state_d  = S_IDLE;
         cnt_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  wait_c  = 1'b1;
                  state_d = S_WAIT;
                  cnt_d   = CW'(1);
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == WS_C) begin
                  complete = 1'b1;
                  state_d  = S_IDLE;
                  cnt_d    = '0;
               end else begin
                  wait_c = 1'b1;
                  cnt_d  = cnt_q + CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Reset silences the bus outputs immediately, even mid-transfer
   assign waitrequest = RAM_Reset & wait_c;
   assign readdata    = (RAM_Reset && complete && read && !write) ? rd_word : 32'h0;

   // Byte-lane merge of the incoming write into the current word
   always_comb begin
      merged = rd_word;
      for (int b = 0; b < 4; b++) begin
         if (byteenable[b]) begin
            merged[8*b +: 8] = writedata[8*b +: 8];
         end
      end
   end

   // Decide what the completing edge will commit
   always_comb begin
      wr_pend_d = complete & write & ~pre_hits_bus & (byteenable != 4'b0000);
      wr_word_d = wr_word_q;
      wr_data_d = wr_data_q;
      if (wr_pend_d) begin
         wr_word_d = bus_word;
         wr_data_d = merged;
      end
   end

   // FSM, wait counter and captured write, all cleared asynchronously
   always_ff @(posedge clk or negedge RAM_Reset) begin
      if (!RAM_Reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         wr_pend_q <= 1'b0;
         wr_word_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_pend_q <= wr_pend_d;
         wr_word_q <= wr_word_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Word storage: reset, then preload, then the captured bus write
   always_latch begin
      for (int i = 0; i < DEPTH; i++) begin
         if (!RAM_Reset) begin
            mem_q[i] <= 32'h0;
         end else if (inst_input && (pre_word == AW'(i))) begin
            mem_q[i] <= instruction;
         end else if (clk && wr_pend_q && (wr_word_q == AW'(i))) begin
            mem_q[i] <= wr_data_q;
         end
      end
   end

endmodule

// File: tb/tb_avalon_boot_ram.sv
// Directed bench for avalon_boot_ram. Two instances share one bus: the main
// one with one wait state, a second with none. Bus reads push their expected
// word into exp_q; the monitor pops and compares on every completed read.
module tb_avalon_boot_ram;

   logic        clk;
   logic        RAM_Reset;
   logic [31:0] address;
   logic        write;
   logic        read;
   logic        waitrequest;
   logic        waitrequest0;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;
   logic [31:0] readdata0;
   logic [31:0] instruction;
   logic        inst_input;
   logic [7:0]  inst_addr;

   logic [31:0] exp_q[$];
   int          n_checks;
   int          n_fail;
   logic        ws0_seen_wait;

   avalon_boot_ram #(.DEPTH(64), .WAIT_STATES(1)) dut (
      .clk         (clk),
      .RAM_Reset   (RAM_Reset),
      .address     (address),
      .write       (write),
      .read        (read),
      .waitrequest (waitrequest),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata),
      .instruction (instruction),
      .inst_input  (inst_input),
      .inst_addr   (inst_addr)
   );

   avalon_boot_ram #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
      .clk         (clk),
      .RAM_Reset   (RAM_Reset),
      .address     (address),
      .write       (write),
      .read        (read),
      .waitrequest (waitrequest0),
      .writedata   (writedata),
      .byteenable  (byteenable),
      .readdata    (readdata0),
      .instruction (instruction),
      .inst_input  (inst_input),
      .inst_addr   (inst_addr)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every completed plain read is scored against the queue
   always @(negedge clk) begin
      if (RAM_Reset && read && !write && !waitrequest) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_read: got %h expected none", readdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check32("readdata", readdata, e);
            check32("readdata_ws0", readdata0, e);
         end
      end
      if (RAM_Reset && waitrequest0) ws0_seen_wait = 1'b1;
   end

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
      int waits;
      bit done;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      address = addr;
      read    = 1'b1;
      waits   = 0;
      done    = 1'b0;
      for (int n = 0; n < 16 && !done; n++) begin
         @(negedge clk);
         if (waitrequest) begin
            waits++;
            check32("readdata_while_waiting", readdata, 32'h0);
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL read_timeout: got waitrequest=1 expected completion at %h", addr);
      end
      check32("read_wait_cycles", 32'(waits), 32'd1);
      @(posedge clk); #1;
      read = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, input logic with_read);
      bit done;
      @(posedge clk); #1;
      address    = addr;
      writedata  = data;
      byteenable = be;
      write      = 1'b1;
      read       = with_read;
      done       = 1'b0;
      for (int n = 0; n < 16 && !done; n++) begin
         @(negedge clk);
         if (!waitrequest) begin
            done = 1'b1;
            if (with_read) check32("read_write_readdata", readdata, 32'h0);
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL write_timeout: got waitrequest=1 expected completion at %h", addr);
      end
      @(posedge clk); #1;
      write = 1'b0;
      read  = 1'b0;
   endtask

   // Single preload pulse placed mid-cycle, away from any clock edge
   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk); #1;
      inst_addr   = a;
      instruction = d;
      inst_input  = 1'b1;
      #1;
      inst_input  = 1'b0;
   endtask

   initial begin
      logic [2:0] seq;
      n_checks      = 0;
      n_fail        = 0;
      ws0_seen_wait = 1'b0;
      RAM_Reset     = 1'b0;
      address       = 32'h8;
      write         = 1'b0;
      read          = 1'b1;
      writedata     = 32'h0;
      byteenable    = 4'h0;
      instruction   = 32'h0;
      inst_input    = 1'b0;
      inst_addr     = 8'h0;

      // Reset holds the bus outputs low even with a request present
      @(negedge clk);
      check32("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
      check32("reset_readdata", readdata, 32'h0);
      @(posedge clk); #1;
      read      = 1'b0;
      RAM_Reset = 1'b1;
      bus_read(32'h8, 32'h0);

      // Preload burst at 1-unit spacing with no clock edge in between
      @(negedge clk); #1;
      inst_addr = 8'h04; instruction = 32'h24030020; inst_input = 1'b1;
      #1;
      inst_addr = 8'h08; instruction = 32'h2882F00F;
      #1;
      inst_addr = 8'h10; instruction = 32'h00000008;
      #1;
      inst_input = 1'b0;
      bus_read(32'h4,  32'h24030020);
      bus_read(32'h8,  32'h2882F00F);
      bus_read(32'h10, 32'h00000008);
      bus_read(32'h0,  32'h0);
      bus_read(32'hC,  32'h0);

      // Byte-enable write: lanes 0 and 2 only
      bus_write(32'h8, 32'hAABBCCDD, 4'b0101, 1'b0);
      bus_read(32'h8, 32'h28BBF0DD);

      // Aliasing of the reset vector and unaligned low bits
      preload(8'h04, 32'h12345678);
      bus_read(32'hBFC00004, 32'h12345678);
      bus_read(32'h00000006, 32'h12345678);

      // Read held three cycles: complete, then a fresh transfer starts
      exp_q.push_back(32'h12345678);
      @(posedge clk); #1;
      address = 32'h4;
      read    = 1'b1;
      seq     = 3'b000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         seq = {seq[1:0], waitrequest};
      end
      @(posedge clk); #1;
      read = 1'b0;
      check32("waitrequest_pattern", {29'b0, seq}, 32'h5);

      // Address wrap by truncation, and an all-lanes-off write
      bus_write(32'h10C, 32'hA5A5A5A5, 4'b1111, 1'b0);
      bus_read(32'hC, 32'hA5A5A5A5);
      bus_write(32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0);
      bus_read(32'h10, 32'h00000008);

      // Read and write together behave as a write
      bus_write(32'h1C, 32'h00000055, 4'b1111, 1'b1);
      bus_read(32'h1C, 32'h00000055);

      // Preload wins over a same-cycle bus write to the same word
      @(negedge clk); #1;
      inst_addr = 8'h14; instruction = 32'h11111111; inst_input = 1'b1;
      bus_write(32'h14, 32'hDEADBEEF, 4'b1111, 1'b0);
      inst_input = 1'b0;
      bus_read(32'h14, 32'h11111111);

      // Asynchronous reset during the wait cycle of a write
      @(posedge clk); #1;
      address = 32'h18; writedata = 32'hCAFEBABE; byteenable = 4'hF; write = 1'b1;
      @(negedge clk);
      check32("midwrite_waitrequest_before", {31'b0, waitrequest}, 32'h1);
      #1;
      RAM_Reset = 1'b0;
      #1;
      check32("midwrite_waitrequest_after", {31'b0, waitrequest}, 32'h0);
      check32("midwrite_readdata", readdata, 32'h0);
      @(posedge clk); #1;
      write = 1'b0;
      @(posedge clk); #1;
      RAM_Reset = 1'b1;
      bus_read(32'h18, 32'h0);
      bus_read(32'h4,  32'h0);

      // Drain and final checks
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(posedge clk);
      check32("queue_empty", 32'(exp_q.size()), 32'h0);
      check32("ws0_waitrequest_never_high", {31'b0, ws0_seen_wait}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
